// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Purpose  : Program-run sequencer and branch decoder driving the PC, with a
//             writable 16-entry branch-target table and run statistics.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
   parameter int unsigned MAX_CYCLES = 1000
) (
   input  logic        CLK,
   input  logic        Reset_n,
   input  logic        Start,
   input  logic [8:0]  Instr,
   input  logic        ALU_zero,
   input  logic        TblWe,
   input  logic [3:0]  TblAddr,
   input  logic [15:0] TblData,
   output logic        Init,
   output logic        Halt,
   output logic        Branch_abs,
   output logic        Branch_rel_en,
   output logic [15:0] Target,
   output logic        Ack,
   output logic        Timeout,
   output logic [15:0] CycleCnt,
   output logic [15:0] BranchCnt
);

   localparam logic [15:0] c_wdog_last = 16'(MAX_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_INIT = 2'd1,
      S_RUN  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next_state;
   logic        r_start_d;
   logic [15:0] r_tbl [16];
   logic [15:0] r_cycle_cnt;
   logic [15:0] r_branch_cnt;
   logic        r_timeout;

   logic        w_start_edge;
   logic        w_is_halt;
   logic        w_wdog;
   logic        w_term;
   logic        w_taken;
   logic [15:0] w_tbl_rd;

   assign w_start_edge = Start & ~r_start_d;
   assign w_is_halt    = (Instr == 9'h1FF);
   assign w_wdog       = (r_cycle_cnt == c_wdog_last);
   assign w_term       = (r_state == S_RUN) && (w_is_halt || w_wdog);
   assign w_tbl_rd     = r_tbl[Instr[3:0]];

   assign CycleCnt  = r_cycle_cnt;
   assign BranchCnt = r_branch_cnt;
   assign Timeout   = r_timeout;

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_state   <= S_IDLE;
         r_start_d <= 1'b0;
      end else begin
         r_state   <= w_next_state;
         r_start_d <= Start;
      end
   end

   always_comb begin
      w_next_state  = r_state;
      Init          = 1'b0;
      Halt          = 1'b0;
      Ack           = 1'b0;
      Branch_abs    = 1'b0;
      Branch_rel_en = 1'b0;
      Target        = 16'h0000;
      w_taken       = 1'b0;
      case (r_state)
         S_IDLE: begin
            Init = 1'b1;
            if (w_start_edge) w_next_state = S_INIT;
         end
         S_INIT: begin
            Init         = 1'b1;
            w_next_state = S_RUN;
         end
         S_RUN: begin
            // A terminating cycle (HALT or watchdog) suppresses all branching.
            if (w_term) begin
               Halt         = 1'b1;
               w_next_state = S_DONE;
            end else if (Instr[8:6] == 3'b111) begin
               Branch_abs = 1'b1;
               Target     = w_tbl_rd;
               w_taken    = 1'b1;
            end else if (Instr[8:6] == 3'b110) begin
               Branch_rel_en = 1'b1;
               Target        = w_tbl_rd;
               w_taken       = ALU_zero;
            end
         end
         S_DONE: begin
            Halt = 1'b1;
            Ack  = 1'b1;
            if (w_start_edge) w_next_state = S_INIT;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         r_cycle_cnt  <= 16'h0000;
         r_branch_cnt <= 16'h0000;
         r_timeout    <= 1'b0;
      end else if (r_state == S_INIT) begin
         r_cycle_cnt  <= 16'h0000;
         r_branch_cnt <= 16'h0000;
         r_timeout    <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_cycle_cnt <= r_cycle_cnt + 16'h0001;
         if (w_taken && (r_branch_cnt != 16'hFFFF))
            r_branch_cnt <= r_branch_cnt + 16'h0001;
         // HALT takes priority over the watchdog in the same cycle.
         if (w_term)
            r_timeout <= ~w_is_halt;
      end
   end

   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         for (int i = 0; i < 16; i++) r_tbl[i] <= 16'h0000;
      end else if (TblWe && (r_state != S_RUN)) begin
         r_tbl[TblAddr] <= TblData;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_sequencer
//  Purpose  : Directed self-checking bench for pc_sequencer (MAX_CYCLES = 8).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_sequencer;

   logic        CLK = 1'b0;
   logic        Reset_n = 1'b1;
   logic        Start = 1'b0;
   logic [8:0]  Instr = 9'h000;
   logic        ALU_zero = 1'b0;
   logic        TblWe = 1'b0;
   logic [3:0]  TblAddr = 4'h0;
   logic [15:0] TblData = 16'h0000;
   logic        Init, Halt, Branch_abs, Branch_rel_en, Ack, Timeout;
   logic [15:0] Target, CycleCnt, BranchCnt;

   pc_sequencer #(.MAX_CYCLES(8)) dut (
      .CLK          (CLK),
      .Reset_n      (Reset_n),
      .Start        (Start),
      .Instr        (Instr),
      .ALU_zero     (ALU_zero),
      .TblWe        (TblWe),
      .TblAddr      (TblAddr),
      .TblData      (TblData),
      .Init         (Init),
      .Halt         (Halt),
      .Branch_abs   (Branch_abs),
      .Branch_rel_en(Branch_rel_en),
      .Target       (Target),
      .Ack          (Ack),
      .Timeout      (Timeout),
      .CycleCnt     (CycleCnt),
      .BranchCnt    (BranchCnt)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string       tag;
      logic [15:0] exp;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;

   task automatic expect_v(input string tag, input logic [15:0] exp);
      exp_t e;
      e.tag = tag;
      e.exp = exp;
      q.push_back(e);
   endtask

   task automatic got(input logic [15:0] obs);
      exp_t e;
      n_total++;
      if (q.size() == 0) begin
         $error("FAIL scoreboard_empty: got %h required an expectation", obs);
      end else begin
         e = q.pop_front();
         assert (obs === e.exp) n_pass++;
         else $error("FAIL %s: got %h required %h", e.tag, obs, e.exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Leaves the DUT in its first RUN cycle; checks the single INIT cycle.
   task automatic start_run(input string tag);
      Start = 1'b0;
      tick();
      Start = 1'b1;
      tick();
      expect_v({tag, "_init"}, 16'd1);
      expect_v({tag, "_init_ack"}, 16'd0);
      got(16'(Init));
      got(16'(Ack));
      tick();
   endtask

   task automatic table_write(input logic [3:0] a, input logic [15:0] d);
      TblWe   = 1'b1;
      TblAddr = a;
      TblData = d;
      tick();
      TblWe   = 1'b0;
   endtask

   initial begin
      #2 Reset_n = 1'b0;
      tick();
      tick();
      expect_v("rst_init", 16'd1);
      expect_v("rst_halt", 16'd0);
      expect_v("rst_ack", 16'd0);
      expect_v("rst_cycle", 16'd0);
      got(16'(Init));
      got(16'(Halt));
      got(16'(Ack));
      got(CycleCnt);
      @(negedge CLK);
      Reset_n = 1'b1;
      tick();

      // Run 1: table writes in IDLE, JMP, BRZ not-taken/taken, HALT
      table_write(4'd3, 16'h0020);
      table_write(4'd5, 16'hFFFE);
      start_run("run1");
      Instr = 9'b111_000011;
      #1;
      expect_v("jmp_abs", 16'd1);
      expect_v("jmp_target", 16'h0020);
      expect_v("jmp_init", 16'd0);
      got(16'(Branch_abs));
      got(Target);
      got(16'(Init));
      tick();
      expect_v("jmp_bcnt", 16'd1);
      got(BranchCnt);
      Instr = 9'b110_000101;
      ALU_zero = 1'b0;
      #1;
      expect_v("brz_rel", 16'd1);
      expect_v("brz_target", 16'hFFFE);
      expect_v("brz_abs", 16'd0);
      got(16'(Branch_rel_en));
      got(Target);
      got(16'(Branch_abs));
      // a table write attempted during RUN must be dropped
      TblWe = 1'b1;
      TblAddr = 4'd3;
      TblData = 16'h1234;
      tick();
      TblWe = 1'b0;
      expect_v("brz_nz_bcnt", 16'd1);
      got(BranchCnt);
      ALU_zero = 1'b1;
      tick();
      expect_v("brz_z_bcnt", 16'd2);
      got(BranchCnt);
      ALU_zero = 1'b0;
      Instr = 9'h1FF;
      #1;
      expect_v("halt_comb", 16'd1);
      expect_v("halt_abs", 16'd0);
      expect_v("halt_target", 16'd0);
      expect_v("halt_ack_pre", 16'd0);
      got(16'(Halt));
      got(16'(Branch_abs));
      got(Target);
      got(16'(Ack));
      tick();
      expect_v("run1_ack", 16'd1);
      expect_v("run1_cycle", 16'd4);
      expect_v("run1_bcnt", 16'd2);
      got(16'(Ack));
      got(CycleCnt);
      got(BranchCnt);
      // Start still held high: no retrigger
      tick();
      tick();
      expect_v("held_start_ack", 16'd1);
      expect_v("held_start_init", 16'd0);
      got(16'(Ack));
      got(16'(Init));

      // Run 2: table unchanged by RUN write, 4 plain cycles then HALT
      start_run("run2");
      expect_v("run2_cnt_clear", 16'd0);
      expect_v("run2_bcnt_clear", 16'd0);
      got(CycleCnt);
      got(BranchCnt);
      Instr = 9'b111_000011;
      #1;
      expect_v("guard_target", 16'h0020);
      got(Target);
      Instr = 9'h000;
      #1;
      expect_v("plain_target", 16'd0);
      got(Target);
      for (int i = 0; i < 4; i++) tick();
      Instr = 9'h1FF;
      tick();
      expect_v("run2_ack", 16'd1);
      expect_v("run2_cycle", 16'd5);
      expect_v("run2_timeout", 16'd0);
      got(16'(Ack));
      got(CycleCnt);
      got(16'(Timeout));

      // Run 3: watchdog with a JMP presented in the terminating cycle
      Instr = 9'h000;
      start_run("run3");
      for (int i = 0; i < 6; i++) tick();
      expect_v("wd_c7_halt", 16'd0);
      got(16'(Halt));
      tick();
      Instr = 9'b111_000011;
      #1;
      expect_v("wd_c8_halt", 16'd1);
      expect_v("wd_c8_abs", 16'd0);
      expect_v("wd_c8_target", 16'd0);
      got(16'(Halt));
      got(16'(Branch_abs));
      got(Target);
      tick();
      expect_v("wd_ack", 16'd1);
      expect_v("wd_timeout", 16'd1);
      expect_v("wd_cycle", 16'd8);
      expect_v("wd_bcnt", 16'd0);
      got(16'(Ack));
      got(16'(Timeout));
      got(CycleCnt);
      got(BranchCnt);

      // Run 4: rerun clears Timeout; HALT coinciding with watchdog
      Instr = 9'h000;
      start_run("run4");
      expect_v("run4_timeout_clr", 16'd0);
      expect_v("run4_cycle_clr", 16'd0);
      got(16'(Timeout));
      got(CycleCnt);
      for (int i = 0; i < 7; i++) tick();
      Instr = 9'h1FF;
      tick();
      expect_v("wdhalt_ack", 16'd1);
      expect_v("wdhalt_timeout", 16'd0);
      expect_v("wdhalt_cycle", 16'd8);
      got(16'(Ack));
      got(16'(Timeout));
      got(CycleCnt);

      // Run 5: asynchronous reset mid-RUN
      Instr = 9'h000;
      start_run("run5");
      tick();
      Instr = 9'b111_000011;
      #2 Reset_n = 1'b0;
      #1;
      expect_v("arst_init", 16'd1);
      expect_v("arst_ack", 16'd0);
      expect_v("arst_abs", 16'd0);
      expect_v("arst_cycle", 16'd0);
      got(16'(Init));
      got(16'(Ack));
      got(16'(Branch_abs));
      got(CycleCnt);
      @(negedge CLK);
      Reset_n = 1'b1;
      Instr = 9'h000;
      start_run("run6");
      Instr = 9'b111_000011;
      #1;
      expect_v("arst_tbl_cleared", 16'd0);
      expect_v("arst_run_abs", 16'd1);
      got(Target);
      got(16'(Branch_abs));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish, got %0d passes required completion", n_pass);
      $fatal(1, "time limit");
   end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Control-side driver for the program counter. Sequences a program run (start, PC initialisation, run, done/ack), decodes the fetched 9-bit instruction into the PC's branch controls (`Branch_abs`, `Branch_rel_en`, `Target`, `Halt`, `Init`) using a writable 16-entry branch-target table, and keeps run statistics. It sits between instruction memory output and the PC, alongside the ALU.

## Interface
- `MAX_CYCLES`, default 1000: RUN-cycle watchdog limit. Legal range is 1..65535.
- `CLK`  in  1  clock; all state changes on posedge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `Start`  in  1  run request; rising edge is detected internally.
- `Instr`  in  9  instruction currently fetched at the PC.
- `ALU_zero`  in  1  ALU zero flag; used only for taken-branch counting.
- `TblWe`  in  1  target-table write enable.
- `TblAddr`  in  4  target-table write index.
- `TblData`  in  16  target-table write data.
- `Init`  out  1  PC reset request.
- `Halt`  out  1  PC freeze.
- `Branch_abs`  out  1  unconditional absolute jump.
- `Branch_rel_en`  out  1  conditional relative-branch enable.
- `Target`  out  16  jump target or signed relative offset.
- `Ack`  out  1  run complete.
- `Timeout`  out  1  last run ended by watchdog.
- `CycleCnt`  out  16  RUN cycles in last/current run.
- `BranchCnt`  out  16  taken branches in last/current run.

## Operation
- **Start edge detect:** `StartEdge = Start & ~Start_d`, where `Start_d` is a register.
- **States:** IDLE, INIT, RUN, DONE.
  - IDLE: `Init`=1. On StartEdge go to INIT.
  - INIT: exactly 1 cycle. `Init`=1. `CycleCnt`, `BranchCnt` and `Timeout` are cleared at the end of this cycle. Next state is RUN.
  - RUN: decode `Instr` every cycle (see below). A HALT instruction or the watchdog moves the state to DONE.
  - DONE: `Halt`=1, `Ack`=1. On StartEdge go to INIT (re-run). Counters hold.
- **Decode:** active only in RUN, and only in a non-terminating cycle; otherwise all branch outputs are 0 and `Target`=0.
  - HALT: `Instr[8:6]`=3'b111 and `Instr[5:0]`=6'h3F. Drives `Halt`=1; next state DONE.
  - JMP: `Instr[8:6]`=3'b111, any other low bits. Drives `Branch_abs`=1, `Target`=Tbl[`Instr[3:0]`].
  - BRZ: `Instr[8:6]`=3'b110. Drives `Branch_rel_en`=1, `Target`=Tbl[`Instr[3:0]`]. The value is a two's-complement offset; the PC wraps modulo 1024.
  - Any other opcode: no branch, `Target`=0.
- **Watchdog:** a RUN cycle where registered `CycleCnt` == `MAX_CYCLES`-1 is terminating.
  - That cycle drives `Halt`=1 with branch outputs 0.
  - Next state is DONE, with `Timeout`<=1.
  - If the same cycle decodes HALT, HALT wins and `Timeout` stays 0.
- **Counters:**
  - `CycleCnt` increments once per RUN cycle, including the terminating cycle. It cannot overflow within the parameter range.
  - `BranchCnt` increments on a JMP cycle, or on a BRZ cycle with `ALU_zero`=1. It saturates at 16'hFFFF.
- **Target table:**
  - 16x16 bits, read combinationally.
  - A write with `TblWe`=1 lands at posedge in IDLE, INIT or DONE. Writes in RUN are ignored.
  - A write and a read of the same entry in the same cycle returns the old value.
- **Output summary:** `Init` = IDLE|INIT. `Halt` = DONE | RUN-terminating cycle. `Ack` = DONE.

## Timing
- **Reset** (async, immediate, including mid-RUN):
  - state IDLE, `Start_d`=0, table all 0, `CycleCnt`=`BranchCnt`=0, `Timeout`=0.
  - Outputs: `Init`=1, `Halt`=0, `Branch_abs`=0, `Branch_rel_en`=0, `Target`=0, `Ack`=0.
- **Start latency:** StartEdge sampled at edge N gives INIT during cycle N..N+1 and RUN from edge N+1. PC=0 in the first RUN cycle.
- **Branch outputs** are combinational from `Instr` and state; zero added latency. The PC acts on them at the next edge.
- **HALT** decoded in cycle k gives `Ack`=1 from edge k+1. `CycleCnt` equals the number of RUN cycles, HALT cycle included.
- **Held Start:** a `Start` held high produces a single edge and does not retrigger a run.

## Test plan
- **Reset:** assert `Reset_n`=0 mid-RUN → immediately state IDLE, `Init`=1, `Ack`=0, counters 0, table 0.
- **Table + JMP:** write Tbl[3]=16'h0020 in IDLE, pulse `Start`, present `Instr`=9'b111_000011 in RUN → `Branch_abs`=1, `Target`=16'h0020, `BranchCnt`=1.
- **BRZ:** Tbl[5]=16'hFFFE.
  - `Instr`=9'b110_000101 with `ALU_zero`=0 → `Branch_rel_en`=1, `Target`=16'hFFFE, `BranchCnt` unchanged.
  - Same instruction with `ALU_zero`=1 → `BranchCnt`+1.
- **HALT:** 4 non-branch cycles then `Instr`=9'h1FF → `Halt`=1 that cycle, `Ack`=1 next edge, `CycleCnt`=5, `Timeout`=0.
- **Watchdog:** `MAX_CYCLES`=8 with no HALT → `Halt`=1 in the 8th RUN cycle, then DONE with `Timeout`=1 and `CycleCnt`=8.
  - HALT exactly in cycle 8 → `Timeout`=0.
- **Rerun + write guard:** a `TblWe` during RUN leaves the table unchanged. A new StartEdge in DONE → one INIT cycle (`Init`=1), counters cleared, RUN resumes. `Start` held high → no second run.
